// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM state encoding,
// BCD digit constants and the nibble clamp used when loading a start value.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Out-of-range nibbles (A-F) become 9 so the count is always valid BCD.
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit down-counter with clamped load and a borrow chain.
// borrow_in requests a decrement; borrow_out asks the next digit to decrement.
import countdown_pkg::*;

module bcd_digit_dec (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] value,
    output logic [BCD_W-1:0] value_next,
    output logic             borrow_out
);

    always_comb begin
        value_next = value;
        if (load) begin
            value_next = clamp_bcd(load_val);
        end else if (borrow_in) begin
            value_next = (value == '0) ? BCD_MAX : value - 1'b1;
        end
    end

    assign borrow_out = borrow_in && (value == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with internal prescaler and start/pause/expire FSM.
// Optional low-time warning output is enabled by defining COUNTDOWN_WARN_EN.
import countdown_pkg::*;

module bcd_countdown_timer #(
    parameter int                   DIGITS   = 4,
    parameter int                   TICK_DIV = 1000000,
    parameter logic [4*DIGITS-1:0]  WARN_VAL = 16'h0010
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] count,
    output logic                tick,
    output logic                running,
    output logic                expired,
    output logic                warn
);

    localparam int            CW      = 4 * DIGITS;
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_TERM = PW'(TICK_DIV - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic          terminal;
    logic          advance;
    logic          dec_en;
    logic [CW-1:0] count_next;
    logic [DIGITS:0] borrow;

    // The prescaler only advances in RUN cycles that are not overridden by
    // load or pause, so a pause keeps any partial tick intact.
    assign terminal = (prescaler == PS_TERM);
    assign advance  = (state == RUN) && !load && !pause;
    assign dec_en   = advance && terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (load) begin
            prescaler <= '0;
        end else if (advance) begin
            prescaler <= terminal ? '0 : prescaler + 1'b1;
        end
    end

    assign borrow[0] = dec_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_dec u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_val   (load_val[i*BCD_W +: BCD_W]),
            .borrow_in  (borrow[i]),
            .value      (count[i*BCD_W +: BCD_W]),
            .value_next (count_next[i*BCD_W +: BCD_W]),
            .borrow_out (borrow[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = (count == '0) ? EXPIRED : RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (dec_en && (count_next == '0)) begin
                        state_next = EXPIRED;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                EXPIRED: state_next = EXPIRED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
        expired = (state == EXPIRED);
    end

    // tick is delayed one edge so it lines up with the count it produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= dec_en;
        end
    end

`ifdef COUNTDOWN_WARN_EN
    // Evaluated on next-state values so warn changes together with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn <= 1'b0;
        end else begin
            warn <= ((state_next == RUN) || (state_next == PAUSE)) &&
                    (count_next <= WARN_VAL) && (count_next != '0);
        end
    end
`else
    logic unused_warn_val;
    assign unused_warn_val = ^WARN_VAL;
    assign warn            = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (DIGITS=4, TICK_DIV=4).
// Warn expectations follow COUNTDOWN_WARN_EN when the bench is built with it.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic [15:0] count;
    logic        tick;
    logic        running;
    logic        expired;
    logic        warn;

    int tests_run  = 0;
    int tests_fail = 0;
    logic warn_on;

    bcd_countdown_timer #(
        .DIGITS   (4),
        .TICK_DIV (4),
        .WARN_VAL (16'h0010)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .count    (count),
        .tick     (tick),
        .running  (running),
        .expired  (expired),
        .warn     (warn)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pulse_load(input logic [15:0] val);
        load     = 1'b1;
        load_val = val;
        applyStimulus(1);
        load     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
    endtask

    initial begin
`ifdef COUNTDOWN_WARN_EN
        warn_on = 1'b1;
`else
        warn_on = 1'b0;
`endif
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
        applyStimulus(2);
        rst = 1'b0;
        checkOutput("reset_count",   count,   16'h0000);
        checkOutput("reset_tick",    tick,    16'h0);
        checkOutput("reset_running", running, 16'h0);
        checkOutput("reset_expired", expired, 16'h0);
        checkOutput("reset_warn",    warn,    16'h0);

        // Basic countdown with digit borrow
        pulse_load(16'h0102);
        checkOutput("load_0102", count, 16'h0102);
        pulse_start();
        checkOutput("run_after_start", running, 16'h1);
        applyStimulus(3);
        checkOutput("pre_tick_count", count, 16'h0102);
        checkOutput("pre_tick_tick",  tick,  16'h0);
        applyStimulus(1);
        checkOutput("dec1_count", count, 16'h0101);
        checkOutput("dec1_tick",  tick,  16'h1);
        applyStimulus(1);
        checkOutput("tick_one_cycle", tick, 16'h0);
        applyStimulus(3);
        checkOutput("dec2_count", count, 16'h0100);
        checkOutput("dec2_tick",  tick,  16'h1);
        applyStimulus(4);
        checkOutput("borrow_count", count, 16'h0099);
        checkOutput("borrow_tick",  tick,  16'h1);

        // Expiry and sticky hold
        pulse_load(16'h0002);
        checkOutput("load_clears_run", running, 16'h0);
        pulse_start();
        applyStimulus(4);
        checkOutput("exp_mid_count", count, 16'h0001);
        applyStimulus(4);
        checkOutput("exp_count",   count,   16'h0000);
        checkOutput("exp_flag",    expired, 16'h1);
        checkOutput("exp_running", running, 16'h0);
        for (int i = 0; i < 20; i++) begin
            start = (i == 10);
            applyStimulus(1);
            checkOutput("exp_hold_count", count, 16'h0000);
        end
        start = 1'b0;
        checkOutput("exp_hold_flag",    expired, 16'h1);
        checkOutput("exp_hold_running", running, 16'h0);

        // Nibble clamping
        pulse_load(16'h00AF);
        checkOutput("clamp_00AF",    count,   16'h0099);
        checkOutput("load_clrs_exp", expired, 16'h0);
        pulse_load(16'hFA3C);
        checkOutput("clamp_FA3C", count, 16'h9939);

        // Pause preserves prescaler
        pulse_load(16'h0050);
        pulse_start();
        applyStimulus(2);
        pause = 1'b1;
        applyStimulus(1);
        pause = 1'b0;
        checkOutput("paused_running", running, 16'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("paused_count", count, 16'h0050);
        end
        pulse_start();
        checkOutput("resume_running", running, 16'h1);
        applyStimulus(1);
        checkOutput("resume_wait_count", count, 16'h0050);
        applyStimulus(1);
        checkOutput("resume_dec_count", count, 16'h0049);
        checkOutput("resume_dec_tick",  tick,  16'h1);

        // load beats pause in the same cycle
        load = 1'b1; pause = 1'b1; load_val = 16'h0033;
        applyStimulus(1);
        load = 1'b0; pause = 1'b0;
        checkOutput("prio_count",   count,   16'h0033);
        checkOutput("prio_running", running, 16'h0);
        checkOutput("prio_tick",    tick,    16'h0);

        // Reset mid-run
        pulse_start();
        applyStimulus(2);
        checkOutput("midrun_count",   count,   16'h0033);
        checkOutput("midrun_running", running, 16'h1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("rst_count",   count,   16'h0000);
        checkOutput("rst_running", running, 16'h0);
        checkOutput("rst_expired", expired, 16'h0);
        checkOutput("rst_tick",    tick,    16'h0);
        checkOutput("rst_warn",    warn,    16'h0);
        pulse_start();
        checkOutput("start_zero_expired", expired, 16'h1);
        checkOutput("start_zero_running", running, 16'h0);

        // Low-time warning
        pulse_load(16'h0012);
        pulse_start();
        applyStimulus(4);
        checkOutput("warn_0011_count", count, 16'h0011);
        checkOutput("warn_0011",       warn,  16'h0);
        for (int d = 10; d >= 1; d--) begin
            applyStimulus(4);
            checkOutput("warn_seq_count", count, {8'h00, 4'(d / 10), 4'(d % 10)});
            checkOutput("warn_seq",       warn,  {15'h0, warn_on});
        end
        applyStimulus(4);
        checkOutput("warn_end_count",   count,   16'h0000);
        checkOutput("warn_end_expired", expired, 16'h1);
        checkOutput("warn_end",         warn,    16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
